// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg : shared definitions for the TDM demultiplexer.
//   - tdm_state_e : framing FSM state (HUNT / LOCKED)
//   - N_CH_DEF    : default number of time-division channels
//   - W_DEF       : default sample width in bits
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int N_CH_DEF = 4;
    localparam int W_DEF    = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_demux_if.sv
// -----------------------------------------------------------------------------
// tdm_demux_if : bundle between a TDM sample source and the demultiplexer.
//
// Handshake: a beat is transferred on a rising clock edge where din_valid=1.
// There is no back-pressure; the demux accepts every valid beat. fsync and din
// are meaningful only while din_valid=1. frame_valid and sync_err are
// single-cycle pulses; ch_data holds between frames.
//
//   din         source -> demux  serial sample
//   din_valid   source -> demux  din carries a sample
//   fsync       source -> demux  marks the channel-0 sample of a frame
//   ch_data     demux  -> sink   demultiplexed frame, channel k at [k*W +: W]
//   frame_valid demux  -> sink   ch_data just updated with a complete frame
//   ch_sel      demux  -> sink   channel the next accepted sample will fill
//   locked      demux  -> sink   framing FSM is LOCKED
//   sync_err    demux  -> sink   framing violation pulse
//   state       demux  -> sink   framing FSM state (debug visibility)
// -----------------------------------------------------------------------------
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int W    = W_DEF
) ();

    localparam int SEL_W = $clog2(N_CH);

    logic [W-1:0]      din;
    logic              din_valid;
    logic              fsync;
    logic [N_CH*W-1:0] ch_data;
    logic              frame_valid;
    logic [SEL_W-1:0]  ch_sel;
    logic              locked;
    logic              sync_err;
    tdm_state_e        state;

    modport master (
        output din, din_valid, fsync,
        input  ch_data, frame_valid, ch_sel, locked, sync_err, state
    );

    modport slave (
        input  din, din_valid, fsync,
        output ch_data, frame_valid, ch_sel, locked, sync_err, state
    );

endinterface

// File: rtl/tdm_demux_ctrl.sv
// -----------------------------------------------------------------------------
// tdm_demux_ctrl : framing FSM and sample-slot counter.
//   clk, rst         clock, asynchronous active-high reset
//   din_valid_i      beat present this cycle
//   fsync_i          frame-start marker on this beat
//   store_o          write din into shadow slot slot_o this edge (comb)
//   slot_o           shadow slot for the current beat (comb)
//   commit_o         this beat completes a frame; copy shadow+din out (comb)
//   state_o          FSM state register
//   ch_sel_o         slot the next accepted beat will fill (registered)
//   locked_o         registered LOCKED flag
//   frame_valid_o    registered frame-complete pulse
//   sync_err_o       registered framing-violation pulse
// -----------------------------------------------------------------------------
module tdm_demux_ctrl
    import tdm_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid_i,
    input  logic             fsync_i,
    output logic             store_o,
    output logic [SEL_W-1:0] slot_o,
    output logic             commit_o,
    output tdm_state_e       state_o,
    output logic [SEL_W-1:0] ch_sel_o,
    output logic             locked_o,
    output logic             frame_valid_o,
    output logic             sync_err_o
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

    tdm_state_e       state_q, state_d;
    logic [SEL_W-1:0] ch_sel_q, ch_sel_d;
    logic             locked_q, frame_valid_q, sync_err_q;
    logic             err;

    // State register (plus counter and registered output pulses)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            ch_sel_q      <= '0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_sel_q      <= ch_sel_d;
            locked_q      <= (state_d == LOCKED);
            frame_valid_q <= commit_o;
            sync_err_q    <= err;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        ch_sel_d = ch_sel_q;
        if (din_valid_i) begin
            if (fsync_i) begin
                // Any fsync beat restarts a frame in slot 0, from either state.
                state_d  = LOCKED;
                ch_sel_d = SEL_W'(1);
            end else if (state_q == LOCKED) begin
                if (ch_sel_q == '0) begin
                    state_d  = HUNT;
                    ch_sel_d = '0;
                end else if (ch_sel_q == LAST) begin
                    ch_sel_d = '0;
                end else begin
                    ch_sel_d = ch_sel_q + SEL_W'(1);
                end
            end
        end
    end

    // Output (control strobe) logic
    always_comb begin
        store_o  = 1'b0;
        slot_o   = '0;
        commit_o = 1'b0;
        err      = 1'b0;
        if (din_valid_i) begin
            if (fsync_i) begin
                store_o = 1'b1;
                // fsync mid-frame (including on the last slot) abandons it.
                err     = (state_q == LOCKED) && (ch_sel_q != '0);
            end else if (state_q == LOCKED) begin
                if (ch_sel_q == '0) begin
                    err = 1'b1;
                end else begin
                    store_o  = 1'b1;
                    slot_o   = ch_sel_q;
                    commit_o = (ch_sel_q == LAST);
                end
            end
        end
    end

    assign state_o       = state_q;
    assign ch_sel_o      = ch_sel_q;
    assign locked_o      = locked_q;
    assign frame_valid_o = frame_valid_q;
    assign sync_err_o    = sync_err_q;

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux : time-division demultiplexer.
// Collects N_CH consecutive valid samples, starting at an fsync-marked beat,
// into a shadow buffer and publishes the complete frame on ch_data with a
// one-cycle frame_valid pulse. Partial frames are never published.
//   clk, rst  clock, asynchronous active-high reset
//   bus       tdm_demux_if slave: din/din_valid/fsync in,
//             ch_data/frame_valid/ch_sel/locked/sync_err/state out
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int W    = W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);

    localparam int SEL_W = $clog2(N_CH);

    logic             store;
    logic [SEL_W-1:0] slot;
    logic             commit;

    logic [W-1:0]      shadow_q [N_CH];
    logic [N_CH*W-1:0] ch_data_q, frame_d;

    tdm_demux_ctrl #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .din_valid_i   (bus.din_valid),
        .fsync_i       (bus.fsync),
        .store_o       (store),
        .slot_o        (slot),
        .commit_o      (commit),
        .state_o       (bus.state),
        .ch_sel_o      (bus.ch_sel),
        .locked_o      (bus.locked),
        .frame_valid_o (bus.frame_valid),
        .sync_err_o    (bus.sync_err)
    );

    // The completing beat is taken straight from din so the frame goes out
    // on the same edge that accepts it.
    always_comb begin
        frame_d = '0;
        for (int k = 0; k < N_CH - 1; k++) begin
            frame_d[k*W +: W] = shadow_q[k];
        end
        frame_d[(N_CH-1)*W +: W] = bus.din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= '0;
            end
            ch_data_q <= '0;
        end else begin
            if (store) begin
                shadow_q[slot] <= bus.din;
            end
            if (commit) begin
                ch_data_q <= frame_d;
            end
        end
    end

    assign bus.ch_data = ch_data_q;

endmodule
